des_expand_pipe: RTL and testbench

Parametrised, pipelined expansion stage for the DES datapath. It widens the DES E-expansion from a fixed 32-to-48 mapping to any width divisible by 4, and optionally XORs a round subkey into the result. The block carries a valid/ready handshake, a configurable register depth and a count of accepted beats. It sits between the round-half register (R) and the S-box stage; with WIDTH=32 it computes E(R) xor K for one DES round.

---
 rtl/des_expand_pipe.sv | 117 +++++++++++
 tb/tb_des_expand_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_expand_pipe.sv
// Generalised DES E-expansion (WIDTH -> WIDTH*3/2) with optional subkey XOR,
// carried through a 1- or 2-stage valid/ready register pipeline with a beat counter.
module des_expand_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:WIDTH]       data_in,
  input  logic [1:WIDTH*3/2]   key_in,
  input  logic                 key_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:WIDTH*3/2]   data_out,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int OW = WIDTH * 3 / 2;
  localparam int G  = WIDTH / 4;

  if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
    $fatal(1, "des_expand_pipe: WIDTH must be a multiple of 4 and at least 8");
  end
  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $fatal(1, "des_expand_pipe: PIPE must be 1 or 2");
  end

  // Each nibble borrows one neighbour bit on each side, wrapping around the word.
  logic [1:OW] expanded;
  logic [1:OW] result;

  for (genvar g = 0; g < G; g++) begin : g_group
    localparam int LSRC = (g == 0) ? WIDTH : 4 * g;
    localparam int RSRC = (g == G - 1) ? 1 : 4 * g + 5;
    assign expanded[6*g+1]       = data_in[LSRC];
    assign expanded[6*g+2:6*g+5] = data_in[4*g+1:4*g+4];
    assign expanded[6*g+6]       = data_in[RSRC];
  end

  assign result = key_en ? (expanded ^ key_in) : expanded;

  logic             s1_vld_q, s1_vld_d;
  logic [1:OW]      s1_dat_q, s1_dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_down_rdy;
  logic             in_xfer;

  assign in_ready = !s1_vld_q || s1_down_rdy;
  assign in_xfer  = in_valid && in_ready;
  assign beat_cnt = cnt_q;

  // ---- stage 1: capture keyed expansion of the accepted beat ----
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_dat_d = s1_dat_q;
    cnt_d    = cnt_q;
    if (in_ready) begin
      s1_vld_d = in_valid;
    end
    if (in_xfer) begin
      s1_dat_d = result;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      cnt_q    <= cnt_d;
    end
  end

  if (PIPE == 2) begin : g_two
    logic        s2_vld_q, s2_vld_d;
    logic [1:OW] s2_dat_q, s2_dat_d;

    assign s1_down_rdy = !s2_vld_q || out_ready;

    // ---- stage 2: output register ----
    always_comb begin
      s2_vld_d = s2_vld_q;
      s2_dat_d = s2_dat_q;
      if (s1_down_rdy) begin
        s2_vld_d = s1_vld_q;
        if (s1_vld_q) begin
          s2_dat_d = s1_dat_q;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s2_vld_d;
        s2_dat_q <= s2_dat_d;
      end
    end

    assign out_valid = s2_vld_q;
    assign data_out  = s2_dat_q;
  end else begin : g_one
    assign s1_down_rdy = out_ready;
    assign out_valid   = s1_vld_q;
    assign data_out    = s1_dat_q;
  end

endmodule

// File: tb/tb_des_expand_pipe.sv
// Bench for des_expand_pipe: three instances (32b/PIPE=1, 32b/PIPE=2, 8b/PIPE=2/CNT_W=4)
// checked against the DES E table and a generic expansion model through scoreboards.
module tb_des_expand_pipe;

  logic clk;
  logic rst_a, rst_b;

  logic        v1, ir1, ke1, ov1, or1;
  logic [31:0] d1;
  logic [47:0] k1, do1;
  logic [15:0] c1;

  logic        v2, ir2, ke2, ov2, or2;
  logic [31:0] d2;
  logic [47:0] k2, do2;
  logic [15:0] c2;

  logic        v3, ir3, ke3, ov3, or3;
  logic [7:0]  d3;
  logic [11:0] k3, do3;
  logic [3:0]  c3;

  int checks   = 0;
  int failures = 0;
  int n_out1 = 0, n_out2 = 0, n_out3 = 0;
  int stalls2 = 0;
  logic stream2 = 1'b0;

  logic [47:0] q1[$];
  logic [47:0] q2[$];
  logic [11:0] q3[$];

  int etab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                    8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  des_expand_pipe #(.WIDTH(32), .PIPE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst_a), .in_valid(v1), .in_ready(ir1), .data_in(d1),
    .key_in(k1), .key_en(ke1), .out_valid(ov1), .out_ready(or1),
    .data_out(do1), .beat_cnt(c1));

  des_expand_pipe #(.WIDTH(32), .PIPE(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst_a), .in_valid(v2), .in_ready(ir2), .data_in(d2),
    .key_in(k2), .key_en(ke2), .out_valid(ov2), .out_ready(or2),
    .data_out(do2), .beat_cnt(c2));

  des_expand_pipe #(.WIDTH(8), .PIPE(2), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst_b), .in_valid(v3), .in_ready(ir3), .data_in(d3),
    .key_in(k3), .key_en(ke3), .out_valid(ov3), .out_ready(or3),
    .data_out(do3), .beat_cnt(c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DES numbering: bit i of the half-block is vector bit 32-i.
  function automatic logic [47:0] model32(input logic [31:0] r, input logic [47:0] k,
                                          input logic ke);
    logic [47:0] e;
    for (int j = 1; j <= 48; j++) e[48-j] = r[32-etab[j-1]];
    return ke ? (e ^ k) : e;
  endfunction

  function automatic logic [11:0] model8(input logic [7:0] r, input logic [11:0] k,
                                         input logic ke);
    logic [11:0] e;
    int src;
    for (int p = 0; p < 12; p++) begin
      src = 4 * (p / 6) + (p % 6);
      if (src == 0) src = 8;
      if (src > 8) src = 1;
      e[11-p] = r[8-src];
    end
    return ke ? (e ^ k) : e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon1
    if (!rst_a && ov1 && or1) begin
      n_out1++;
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_out actual=%0h required=no_output", do1);
      end else chk("u1_scoreboard", do1, q1.pop_front());
    end
    if (!rst_a && v1 && ir1) q1.push_back(model32(d1, k1, ke1));
  end

  always @(negedge clk) begin : mon2
    if (stream2 && v2 && !ir2) stalls2++;
    if (!rst_a && ov2 && or2) begin
      n_out2++;
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL u2_unexpected_out actual=%0h required=no_output", do2);
      end else chk("u2_scoreboard", do2, q2.pop_front());
    end
    if (!rst_a && v2 && ir2) q2.push_back(model32(d2, k2, ke2));
  end

  always @(negedge clk) begin : mon3
    if (!rst_b && ov3 && or3) begin
      n_out3++;
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL u3_unexpected_out actual=%0h required=no_output", do3);
      end else chk("u3_scoreboard", do3, q3.pop_front());
    end
    if (!rst_b && v3 && ir3) q3.push_back(model8(d3, k3, ke3));
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] d;
    logic [47:0] k;
    logic        ke;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [6];
  logic [63:0] r64;
  logic [47:0] bp_exp0;
  int n0;

  initial begin
    vecs[0] = '{32'h80000001, 48'h0,            1'b0, 48'hC00000000003};
    vecs[1] = '{32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 48'h000000000000};
    vecs[2] = '{32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 48'hFFFFFFFFFFFF};
    vecs[3] = '{32'h00000000, 48'h123456789ABC, 1'b1, 48'h123456789ABC};
    vecs[4] = '{32'hF0F0F0F0, 48'hFFFFFFFFFFFF, 1'b0, 48'h7A17A17A17A1};
    vecs[5] = '{32'h00000001, 48'h0,            1'b1, 48'h800000000002};

    rst_a = 1'b1; rst_b = 1'b1;
    v1 = 0; d1 = '0; k1 = '0; ke1 = 0; or1 = 1;
    v2 = 0; d2 = '0; k2 = '0; ke2 = 0; or2 = 1;
    v3 = 0; d3 = '0; k3 = '0; ke3 = 0; or3 = 1;
    repeat (2) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("rst_u1_out_valid", ov1, 0);
    chk("rst_u1_data_out", do1, 0);
    chk("rst_u1_beat_cnt", c1, 0);
    chk("rst_u1_in_ready", ir1, 1);
    chk("rst_u2_out_valid", ov2, 0);
    chk("rst_u2_in_ready", ir2, 1);
    chk("rst_u3_beat_cnt", c3, 0);

    // Single beats through the one-stage instance.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      v1 = 1; d1 = vecs[i].d; k1 = vecs[i].k; ke1 = vecs[i].ke;
      @(posedge clk); #1;
      v1 = 0;
      @(negedge clk);
      chk("u1_vec_valid", ov1, 1);
      chk("u1_vec_data", do1, vecs[i].exp);
      chk("u1_vec_cnt", c1, 64'(i + 1));
    end

    // Backpressure on the two-stage instance.
    @(posedge clk); #1;
    or2 = 0; v2 = 1; d2 = 32'h12345678; k2 = '0; ke2 = 0;
    bp_exp0 = model32(32'h12345678, 48'h0, 1'b0);
    @(posedge clk); #1;
    d2 = 32'h9ABCDEF0;
    @(negedge clk);
    chk("u2_latency_not_yet", ov2, 0);
    @(posedge clk); #1;
    d2 = 32'h0F1E2D3C;
    @(negedge clk);
    chk("u2_bp_valid", ov2, 1);
    chk("u2_bp_in_ready", ir2, 0);
    chk("u2_bp_data", do2, bp_exp0);
    repeat (3) @(negedge clk);
    chk("u2_bp_hold_valid", ov2, 1);
    chk("u2_bp_hold_data", do2, bp_exp0);
    chk("u2_bp_cnt", c2, 2);
    chk("u2_bp_hold_ready", ir2, 0);
    @(posedge clk); #1;
    or2 = 1;
    @(posedge clk); #1;
    v2 = 0;
    repeat (6) @(negedge clk);
    chk("u2_bp_drained", q2.size(), 0);
    chk("u2_bp_outputs", n_out2, 3);
    chk("u2_bp_cnt_final", c2, 3);

    // 100 back-to-back random beats, output always ready.
    @(posedge clk); #1; rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0;
    n_out2 = 0; stalls2 = 0; stream2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      r64 = {$urandom(), $urandom()};
      v2 = 1; d2 = $urandom(); k2 = r64[47:0]; ke2 = r64[63];
    end
    @(posedge clk); #1;
    v2 = 0; stream2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("u2_stream_stalls", stalls2, 0);
    chk("u2_stream_outputs", n_out2, 100);
    chk("u2_stream_cnt", c2, 100);
    chk("u2_stream_drained", q2.size(), 0);

    // Narrow instance: fixed vector, then counter wrap.
    @(posedge clk); #1;
    v3 = 1; d3 = 8'hA5; k3 = '0; ke3 = 0;
    @(posedge clk); #1;
    v3 = 0;
    @(negedge clk);
    chk("u3_latency_not_yet", ov3, 0);
    @(negedge clk);
    chk("u3_a5_valid", ov3, 1);
    chk("u3_a5_data", do3, 12'hD0B);
    chk("u3_a5_cnt", c3, 1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      r64 = {$urandom(), $urandom()};
      v3 = 1; d3 = r64[7:0]; k3 = r64[19:8]; ke3 = r64[32];
    end
    @(posedge clk); #1;
    v3 = 0;
    repeat (5) @(negedge clk);
    chk("u3_cnt_wrap_zero", c3, 0);
    @(posedge clk); #1;
    v3 = 1; d3 = 8'h5A; k3 = 12'hFFF; ke3 = 1;
    @(posedge clk); #1;
    v3 = 0;
    repeat (4) @(negedge clk);
    chk("u3_cnt_after_wrap", c3, 1);
    chk("u3_wrap_drained", q3.size(), 0);

    // Asynchronous reset with beats in flight.
    @(posedge clk); #1;
    or3 = 0; v3 = 1; d3 = 8'h3C; k3 = '0; ke3 = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("u3_full_valid", ov3, 1);
    chk("u3_full_in_ready", ir3, 0);
    chk("u3_full_cnt", c3, 3);
    #2; rst_b = 1'b1;
    #1;
    chk("u3_async_rst_valid", ov3, 0);
    chk("u3_async_rst_cnt", c3, 0);
    chk("u3_async_rst_data", do3, 0);
    chk("u3_async_rst_in_ready", ir3, 1);
    q3.delete();
    v3 = 0;
    @(posedge clk); #1;
    rst_b = 1'b0; or3 = 1;
    n0 = n_out3;
    repeat (6) @(negedge clk);
    chk("u3_no_output_after_rst", n_out3, 64'(n0));
    chk("u3_idle_after_rst", ov3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
